// File: rtl/exec_pkg.sv
// Shared types and widths for the execute stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package exec_pkg;

  localparam int DW         = 8;
  localparam int AW         = 5;
  localparam int MUL_CYCLES = DW;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_LSL = 3'd5,
    OP_LSR = 3'd6,
    OP_MUL = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    WB   = 2'd2
  } state_t;

endpackage

// File: rtl/exec_if.sv
// Request/write-back bundle between register file and execute stage.
// Latency: n/a (wires only).
// Backpressure: requester must watch busy; start is ignored while busy.
interface exec_if import exec_pkg::*; ();

  logic          start;
  op_t           op;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [AW-1:0] dst;
  logic          busy;
  logic          wr_en;
  logic [AW-1:0] wr_ptr;
  logic [DW-1:0] wr_data;
  logic          overflow;

  modport master (
    output start, op, a, b, dst,
    input  busy, wr_en, wr_ptr, wr_data, overflow
  );

  modport slave (
    input  start, op, a, b, dst,
    output busy, wr_en, wr_ptr, wr_data, overflow
  );

endinterface

// File: rtl/exec_mul_iter.sv
// Shift-add multiplier datapath: one multiplier bit per step.
// Latency: MUL_CYCLES steps after load; prod_nxt is the product on the last step.
// Backpressure: none; stepping is fully controlled by the parent FSM.
module exec_mul_iter import exec_pkg::*; (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [2*DW-1:0] prod_nxt,
  output logic            last
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  logic [2*DW-1:0] acc_q, acc_d;
  logic [2*DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Accumulate the shifted multiplicand whenever the current multiplier LSB is set.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    prod_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    last     = (cnt_q == CW'(1));
    if (load) begin
      acc_d    = '0;
      mcand_d  = {{DW{1'b0}}, a};
      mplier_d = b;
      cnt_d    = CW'(MUL_CYCLES);
    end else if (step) begin
      acc_d    = prod_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
    end
  end

  // Datapath registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// 8-bit execute stage: ALU ops in one cycle, shifts and MUL iterate, one write-back beat each.
// Latency: logic ops 1 cycle, shifts 1+b[2:0], MUL 1+MUL_CYCLES from the accepting edge.
// Backpressure: busy high outside IDLE; start is only sampled in IDLE, so issue rate is at most 1 per 2 cycles.
module exec_unit import exec_pkg::*; (
  input  logic clk,
  input  logic reset,
  exec_if.slave bus
);

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic [DW-1:0] res_q, res_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] dst_q, dst_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          ovf_q, ovf_d;

  logic            mul_load, mul_step, mul_last;
  logic [2*DW-1:0] mul_prod;
  logic            wb_go, wb_ovf;
  logic [DW-1:0]   wb_data;
  logic [DW:0]     sum, diff;

  exec_mul_iter u_mul (
    .clk      (clk),
    .reset    (reset),
    .load     (mul_load),
    .step     (mul_step),
    .a        (bus.a),
    .b        (bus.b),
    .prod_nxt (mul_prod),
    .last     (mul_last)
  );

  // Next-state and write-back selection; outputs are loaded on the edge that enters WB.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    dst_d     = dst_q;
    wr_en_d   = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    wr_data_d = wr_data_q;
    ovf_d     = ovf_q;
    mul_load  = 1'b0;
    mul_step  = 1'b0;
    wb_go     = 1'b0;
    wb_data   = '0;
    wb_ovf    = 1'b0;
    sum       = {1'b0, bus.a} + {1'b0, bus.b};
    diff      = {1'b0, bus.a} - {1'b0, bus.b};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d  = bus.op;
          dst_d = bus.dst;
          cnt_d = bus.b[2:0];
          case (bus.op)
            OP_ADD: begin wb_go = 1'b1; wb_data = sum[DW-1:0];  wb_ovf = sum[DW];  end
            OP_SUB: begin wb_go = 1'b1; wb_data = diff[DW-1:0]; wb_ovf = diff[DW]; end
            OP_AND: begin wb_go = 1'b1; wb_data = bus.a & bus.b; end
            OP_OR:  begin wb_go = 1'b1; wb_data = bus.a | bus.b; end
            OP_XOR: begin wb_go = 1'b1; wb_data = bus.a ^ bus.b; end
            OP_LSL, OP_LSR: begin
              res_d = bus.a;
              if (bus.b[2:0] == 3'd0) begin
                wb_go   = 1'b1;
                wb_data = bus.a;
              end else begin
                state_d = ITER;
              end
            end
            OP_MUL: begin
              mul_load = 1'b1;
              state_d  = ITER;
            end
          endcase
          if (wb_go) res_d = wb_data;
        end
      end
      ITER: begin
        if (op_q == OP_MUL) begin
          mul_step = 1'b1;
          if (mul_last) begin
            wb_go   = 1'b1;
            wb_data = mul_prod[DW-1:0];
            wb_ovf  = |mul_prod[2*DW-1:DW];
            res_d   = mul_prod[DW-1:0];
          end
        end else begin
          if (op_q == OP_LSL) begin
            wb_ovf = res_q[DW-1];
            res_d  = res_q << 1;
          end else begin
            wb_ovf = res_q[0];
            res_d  = res_q >> 1;
          end
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            wb_go   = 1'b1;
            wb_data = res_d;
          end
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Register 0 is never written; ptr/data only move when a write actually happens.
    if (wb_go) begin
      state_d = WB;
      ovf_d   = wb_ovf;
      wr_en_d = (dst_d != '0);
      if (dst_d != '0) begin
        wr_ptr_d  = dst_d;
        wr_data_d = wb_data;
      end
    end
  end

  // FSM state, captured request and registered write-back outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      res_q     <= '0;
      cnt_q     <= '0;
      dst_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_ptr_q  <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      dst_q     <= dst_d;
      wr_en_q   <= wr_en_d;
      wr_ptr_q  <= wr_ptr_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_ptr   = wr_ptr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_exec_unit.sv
// Randomized bench for exec_unit against an arithmetic reference model.
// Latency: checks every cycle of each operation, including the exact write-back cycle.
// Backpressure: pulses junk start requests while busy and expects them to be ignored.
module tb_exec_unit;
  import exec_pkg::*;

  logic clk;
  logic reset;
  exec_if bus ();

  exec_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // expected held output state
  logic       exp_ovf;
  logic [4:0] exp_ptr;
  logic [7:0] exp_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour straight from the arithmetic rules.
  function automatic void model(input op_t op, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] d, output logic o, output int lat);
    int ai;
    int bi;
    int n;
    int r;
    ai  = int'(a);
    bi  = int'(b);
    n   = bi % 8;
    lat = 1;
    o   = 1'b0;
    d   = 8'h00;
    case (op)
      OP_ADD: begin r = ai + bi; d = 8'(r); o = (r > 255); end
      OP_SUB: begin r = ai - bi; d = 8'(r); o = (ai < bi); end
      OP_AND: d = a & b;
      OP_OR:  d = a | b;
      OP_XOR: d = a ^ b;
      OP_LSL: begin
        r   = ai << n;
        d   = 8'(r);
        o   = (n == 0) ? 1'b0 : (((ai >> (8 - n)) & 1) != 0);
        lat = 1 + n;
      end
      OP_LSR: begin
        d   = 8'(ai >> n);
        o   = (n == 0) ? 1'b0 : (((ai >> (n - 1)) & 1) != 0);
        lat = 1 + n;
      end
      OP_MUL: begin r = ai * bi; d = 8'(r); o = (r > 255); lat = 9; end
    endcase
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
    chk({tag, "_ovf"}, bus.overflow, exp_ovf);
    chk({tag, "_ptr"}, bus.wr_ptr, exp_ptr);
    chk({tag, "_data"}, bus.wr_data, exp_data);
  endtask

  // Called at a negedge while idle; returns at the negedge of the following idle cycle.
  task automatic do_op(input op_t op, input logic [7:0] a, input logic [7:0] b, input logic [4:0] dst);
    logic [7:0] ed;
    logic       eo;
    int         lat;
    model(op, a, b, ed, eo, lat);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.dst   = dst;
    @(posedge clk);
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(negedge clk);
      chk("busy", bus.busy, 1);
      if (cyc < lat) begin
        chk("wr_en_early", bus.wr_en, 0);
        // junk requests while busy must be ignored
        bus.start = 1'($urandom_range(0, 1));
        bus.op    = op_t'($urandom_range(0, 7));
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        bus.dst   = 5'($urandom);
      end else begin
        exp_ovf = eo;
        if (dst != 5'd0) begin
          exp_ptr  = dst;
          exp_data = ed;
        end
        chk("wb_wr_en", bus.wr_en, (dst != 5'd0));
        chk("wb_ovf", bus.overflow, eo);
        chk("wb_ptr", bus.wr_ptr, exp_ptr);
        chk("wb_data", bus.wr_data, exp_data);
        bus.start = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    check_idle("post");
  endtask

  task automatic clear_model();
    exp_ovf  = 1'b0;
    exp_ptr  = 5'd0;
    exp_data = 8'd0;
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = OP_ADD;
    bus.a     = 8'd0;
    bus.b     = 8'd0;
    bus.dst   = 5'd0;
    clear_model();
    repeat (2) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    // directed cases
    do_op(OP_ADD, 8'd200, 8'd100, 5'd3);
    do_op(OP_AND, 8'hF0, 8'h3C, 5'd3);
    do_op(OP_SUB, 8'd5, 8'd7, 5'd2);
    do_op(OP_SUB, 8'd5, 8'd7, 5'd0);
    do_op(OP_LSL, 8'h81, 8'd3, 5'd4);
    do_op(OP_LSL, 8'h81, 8'h0A, 5'd5);
    do_op(OP_LSR, 8'h05, 8'd0, 5'd6);
    do_op(OP_MUL, 8'd15, 8'd17, 5'd7);
    do_op(OP_MUL, 8'd16, 8'd16, 5'd8);

    // asynchronous reset between edges clears outputs at once
    #2 reset = 1'b1;
    #1;
    clear_model();
    check_idle("async_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset during MUL iteration aborts it
    do_op(OP_SUB, 8'd5, 8'd7, 5'd9);
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.a     = 8'd15;
    bus.b     = 8'd17;
    bus.dst   = 5'd10;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    clear_model();
    check_idle("mul_abort");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_wr", bus.wr_en, 0);
    end
    check_idle("abort_after");
    do_op(OP_ADD, 8'd1, 8'd2, 5'd11);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      op_t        op;
      logic [4:0] dst;
      op  = op_t'($urandom_range(0, 7));
      dst = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      do_op(op, 8'($urandom), 8'($urandom), dst);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage directly downstream of the register file.
- Consumes the two read operands and the destination pointer, and performs one 8-bit ALU operation per accepted request.
- Single-cycle ops: ADD, SUB, AND, OR, XOR. Iterative ops: LSL, LSR, MUL.
- Returns a write-back beat (write enable, pointer, data) to the register file's write port, plus a held overflow flag that drives the register file's r_overflow input (mirrored into r8).

Parameters:
- DW, 8, datapath width; result and operands are DW bits.
- AW, 5, register pointer width.
- MUL_CYCLES, 8, iterations for MUL; must equal DW.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request valid; sampled only in IDLE.
- op  in  3  operation code (op_t).
- a  in  DW  operand A (register file do_a).
- b  in  DW  operand B (register file do_b; may be a constant).
- dst  in  AW  destination register pointer.
- busy  out  1  high whenever state != IDLE.
- wr_en  out  1  one-cycle write-back strobe to the register file.
- wr_ptr  out  AW  write-back pointer.
- wr_data  out  DW  write-back value.
- overflow  out  1  sticky-until-next-op flag; drives r_overflow.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; busy, wr_en, wr_ptr, wr_data, overflow all 0.
  - All internal accumulator, counter and capture registers are cleared.
- Reset asserted mid-operation aborts the operation: no write-back occurs and overflow is cleared.
- FSM states: IDLE, ITER, WB.
- IDLE:
  - If start=1, capture op, a, b and dst.
  - ADD, SUB, AND, OR, XOR: compute into the result register, then go to WB.
  - LSL, LSR: load count = b[2:0]. If count = 0, go to WB with result = a and ovf = 0; otherwise go to ITER.
  - MUL: clear the 2*DW-bit accumulator, set count = MUL_CYCLES, go to ITER.
  - If start=0, remain in IDLE.
- ITER (one step per cycle):
  - LSL: ovf = result[DW-1]; result <<= 1.
  - LSR: ovf = result[0]; result >>= 1.
  - MUL: shift-add using the multiplier LSB of b, one bit per cycle.
  - Decrement count; go to WB when count reaches 0.
  - start is ignored in ITER.
- WB (exactly one cycle):
  - wr_en = (dst_q != 0), so register 0 is never written.
  - wr_ptr = dst_q; wr_data = result.
  - overflow updates on this cycle regardless of dst.
  - Return to IDLE. start is ignored in WB, so back-to-back requests issue every 2 cycles at most.
- Latency from the accepting edge to the wr_en cycle:
  - Single-cycle ops: 1 cycle.
  - Shifts: 1 + b[2:0] cycles.
  - MUL: 1 + MUL_CYCLES cycles.
- Arithmetic rules (full-adder width DW+1):
  - ADD: overflow = carry out.
  - SUB: a - b; overflow = borrow (a < b unsigned).
  - AND, OR, XOR: overflow = 0.
  - Shifts: overflow = last bit shifted out.
  - MUL: wr_data = low byte of the product; overflow = OR-reduction of the high byte.
- Shift amount uses b[2:0] only; b[7:3] is ignored.
- overflow holds its value between write-backs.
- wr_ptr and wr_data hold their last values when wr_en = 0.
- Unused op encodings do not exist; op is 3 bits and fully decoded.

Decomposition:
- Package exec_pkg holds:
  - op_t enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, LSL=5, LSR=6, MUL=7.
  - state_t enum: IDLE, ITER, WB.
  - DW and AW localparams.
- One natural sub-module: exec_mul_iter, the shift-add multiplier datapath (accumulator, counter, done). The FSM stays in exec_unit.

Test Plan:
- reset pulsed asynchronously mid-cycle -> all outputs 0 immediately; state IDLE.
- ADD, a=200, b=100, dst=3 -> next cycle wr_en=1, wr_ptr=3, wr_data=44, overflow=1. Then AND, a=0xF0, b=0x3C -> wr_data=0x30, overflow=0.
- SUB, a=5, b=7, dst=2 -> wr_data=0xFE, overflow=1. Same op with dst=0 -> wr_en stays 0 but overflow=1.
- LSL, a=0x81, b=3 -> busy for 4 cycles, wr_data=0x08 with wr_en on cycle 4, overflow=0. LSL with b=0x0A (amount 2) -> wr_data=0x04, overflow=0. LSR, a=0x05, b=0 -> wr_data=0x05 after 1 cycle, overflow=0.
- MUL, a=15, b=17 -> wr_en on cycle 9, wr_data=0xFF, overflow=0. MUL, a=16, b=16 -> wr_data=0x00, overflow=1. start pulses during busy -> ignored, exactly one write-back.
- MUL started, then reset asserted at ITER cycle 4 -> no wr_en; overflow=0. A new ADD after reset completes normally.
